// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types and constants for the multiplier-sharing arbiter
package mult_share_pkg;

  typedef logic signed [7:0]  operand_t;
  typedef logic signed [15:0] product_t;

  localparam int NREQ_DEFAULT         = 4;
  localparam int MULT_LATENCY_DEFAULT = 2;

  function automatic int tag_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; owns the priority pointer
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic                         advance,
  output logic [NREQ-1:0]              gnt,
  output logic [tag_width(NREQ)-1:0]   gnt_idx
);

  localparam int TW = tag_width(NREQ);

  logic [TW-1:0] r_ptr;
  logic [TW-1:0] w_idx;
  logic          w_found;

  // Scan starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = TW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= TW'(NREQ - 1);
    end else if (advance && w_found) begin
      r_ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - shares one pipelined signed 8x8 multiplier among NREQ requesters
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ         = NREQ_DEFAULT,
  parameter int MULT_LATENCY = MULT_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][7:0]  req_a,
  input  logic [NREQ-1:0][7:0]  req_b,
  output logic [NREQ-1:0]       resp_valid,
  output logic [15:0]           resp_prod,
  output logic                  busy
);

  localparam int TW = tag_width(NREQ);

  logic [TW-1:0] w_gnt_idx;
  logic          w_xfer;

  logic          r_vld0;
  logic [TW-1:0] r_tag0;
  operand_t      r_a;
  operand_t      r_b;
  product_t      w_prod0;

  logic          w_out_vld;
  logic [TW-1:0] w_out_tag;
  product_t      w_out_prod;
  logic          w_busy_tail;

  // Any valid request is granted, so a transfer happens whenever one is present.
  assign w_xfer = |req_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (w_xfer),
    .gnt     (req_ready),
    .gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld0 <= 1'b0;
      r_tag0 <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else begin
      r_vld0 <= w_xfer;
      if (w_xfer) begin
        r_tag0 <= w_gnt_idx;
        r_a    <= operand_t'(req_a[w_gnt_idx]);
        r_b    <= operand_t'(req_b[w_gnt_idx]);
      end
    end
  end

  assign w_prod0 = product_t'(r_a) * product_t'(r_b);

  // Data registers only load behind a valid bit, which keeps resp_prod stable between results.
  generate
    if (MULT_LATENCY == 1) begin : g_lat1
      assign w_out_vld   = r_vld0;
      assign w_out_tag   = r_tag0;
      assign w_out_prod  = w_prod0;
      assign w_busy_tail = 1'b0;
    end else begin : g_latn
      logic [MULT_LATENCY-1:1] r_vld;
      product_t                r_prod [1:MULT_LATENCY-1];
      logic [TW-1:0]           r_tag  [1:MULT_LATENCY-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_vld <= '0;
          for (int k = 1; k < MULT_LATENCY; k++) begin
            r_prod[k] <= '0;
            r_tag[k]  <= '0;
          end
        end else begin
          r_vld[1] <= r_vld0;
          if (r_vld0) begin
            r_prod[1] <= w_prod0;
            r_tag[1]  <= r_tag0;
          end
          for (int k = 2; k < MULT_LATENCY; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
              r_prod[k] <= r_prod[k-1];
              r_tag[k]  <= r_tag[k-1];
            end
          end
        end
      end

      assign w_out_vld   = r_vld[MULT_LATENCY-1];
      assign w_out_tag   = r_tag[MULT_LATENCY-1];
      assign w_out_prod  = r_prod[MULT_LATENCY-1];
      assign w_busy_tail = |r_vld;
    end
  endgenerate

  always_comb begin
    resp_valid = '0;
    if (w_out_vld) begin
      resp_valid[w_out_tag] = 1'b1;
    end
  end

  assign resp_prod = w_out_prod;
  assign busy      = r_vld0 | w_busy_tail;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - scoreboard bench for mult_share_arbiter
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0][7:0] req_a;
  logic [NREQ-1:0][7:0] req_b;
  logic [NREQ-1:0]      resp_valid;
  logic [15:0]          resp_prod;
  logic                 busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .MULT_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_prod  (resp_prod),
    .busy       (busy)
  );

  typedef struct {
    int          tag;
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t            sb[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc      = 0;
  int              m_ptr    = NREQ - 1;
  logic [15:0]     last_prod = '0;
  logic [NREQ-1:0] xfer_mask = '0;
  int              wait_cnt [NREQ];
  int              max_wait = 0;
  int              n_acc    = 0;
  int              n_resp   = 0;

  // One clock: model the grant, score responses, record transfers.
  task automatic cycle();
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_rv;
    int              gidx;
    bit              found;
    bit              rst_s;
    exp_t            e;
    int              pa;
    int              pb;
    @(negedge clk);
    rst_s   = reset;
    exp_gnt = '0;
    found   = 1'b0;
    gidx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found        = 1'b1;
        gidx         = idx;
        exp_gnt[idx] = 1'b1;
      end
    end
    n_checks++;
    if (req_ready !== exp_gnt) begin
      n_errors++;
      $display("FAIL grant cyc=%0d: got %b expected %b", cyc, req_ready, exp_gnt);
    end
    n_checks++;
    if (busy !== (sb.size() != 0)) begin
      n_errors++;
      $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, sb.size() != 0);
    end
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e      = sb.pop_front();
      exp_rv = NREQ'(1) << e.tag;
      n_checks++;
      if (resp_valid !== exp_rv || resp_prod !== e.prod) begin
        n_errors++;
        $display("FAIL resp cyc=%0d: got valid=%b prod=%h expected valid=%b prod=%h",
                 cyc, resp_valid, resp_prod, exp_rv, e.prod);
      end
      last_prod = e.prod;
      n_resp++;
    end else begin
      n_checks++;
      if (resp_valid !== '0 || resp_prod !== last_prod) begin
        n_errors++;
        $display("FAIL idle cyc=%0d: got valid=%b prod=%h expected valid=0 prod=%h",
                 cyc, resp_valid, resp_prod, last_prod);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !exp_gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    xfer_mask = '0;
    if (!rst_s && found) begin
      pa     = $signed(req_a[gidx]);
      pb     = $signed(req_b[gidx]);
      e.tag  = gidx;
      e.prod = 16'(pa * pb);
      e.due  = cyc + LAT;
      sb.push_back(e);
      m_ptr     = gidx;
      xfer_mask = exp_gnt;
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      n_acc    -= sb.size();
      sb.delete();
      m_ptr     = NREQ - 1;
      last_prod = '0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    cycle();
    cycle();
    reset = 1'b0;
    n_checks++;
    if (resp_valid !== '0 || resp_prod !== 16'h0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%b prod=%h busy=%b expected 0/0000/0", resp_valid, resp_prod, busy);
    end
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_priority: got %b expected 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0001;
    req_a[0]  = 8'd3;
    req_b[0]  = 8'hFE;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    cycle();
    req_valid = '0;
    n_checks++;
    if (busy !== 1'b1 || resp_valid !== '0) begin
      n_errors++;
      $display("FAIL single_flight: got busy=%b valid=%b expected busy=1 valid=0000", busy, resp_valid);
    end
    cycle();
    n_checks++;
    if (resp_valid !== 4'b0001 || resp_prod !== 16'hFFFA || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL single_resp: got valid=%b prod=%h busy=%b expected 0001/fffa/1", resp_valid, resp_prod, busy);
    end
    cycle();
    n_checks++;
    if (resp_valid !== '0 || resp_prod !== 16'hFFFA || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_hold: got valid=%b prod=%h busy=%b expected 0000/fffa/0", resp_valid, resp_prod, busy);
    end
  endtask

  task automatic test_corners();
    logic [7:0]  ca [3] = '{8'h80, 8'h7F, 8'h00};
    logic [7:0]  cb [3] = '{8'h80, 8'h80, 8'hFF};
    logic [15:0] cp [3] = '{16'h4000, 16'hC080, 16'h0000};
    for (int t = 0; t < 3; t++) begin
      req_valid = 4'b0010;
      req_a[1]  = ca[t];
      req_b[1]  = cb[t];
      cycle();
      req_valid = '0;
      repeat (LAT - 1) cycle();
      n_checks++;
      if (resp_valid !== 4'b0010 || resp_prod !== cp[t]) begin
        n_errors++;
        $display("FAIL corner%0d: got valid=%b prod=%h expected 0010/%h", t, resp_valid, resp_prod, cp[t]);
      end
      cycle();
    end
  endtask

  task automatic test_fairness();
    int tg;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 8'(i + 1);
      req_b[i] = 8'd10;
    end
    req_valid = '1;
    for (int k = 0; k < 8 + LAT; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      if (k < 8) begin
        n_checks++;
        if (req_ready !== (NREQ'(1) << (k % NREQ))) begin
          n_errors++;
          $display("FAIL fair_grant k=%0d: got %b expected %b", k, req_ready, NREQ'(1) << (k % NREQ));
        end
      end
      if (k >= LAT) begin
        tg = (k - LAT) % NREQ;
        n_checks++;
        if (resp_valid !== (NREQ'(1) << tg) || resp_prod !== 16'(10 * (tg + 1))) begin
          n_errors++;
          $display("FAIL fair_resp k=%0d: got valid=%b prod=%0d expected tag=%0d prod=%0d",
                   k, resp_valid, resp_prod, tg, 10 * (tg + 1));
        end
      end
      cycle();
    end
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] pat [4] = '{4'b0100, 4'b1010, 4'b1010, 4'b1000};
    logic [NREQ-1:0] exg [4] = '{4'b0100, 4'b1000, 4'b0010, 4'b1000};
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 8'(i - 2);
      req_b[i] = 8'(7 * i + 1);
    end
    for (int s = 0; s < 4; s++) begin
      req_valid = pat[s];
      #1;
      n_checks++;
      if (req_ready !== exg[s]) begin
        n_errors++;
        $display("FAIL rotation s=%0d: got %b expected %b", s, req_ready, exg[s]);
      end
      cycle();
    end
    req_valid = '0;
    repeat (LAT) cycle();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req_valid = 4'b0001;
    req_a[0]  = 8'd5;
    req_b[0]  = 8'd5;
    cycle();
    req_valid = 4'b0010;
    req_a[1]  = 8'hFD;
    req_b[1]  = 8'd7;
    cycle();
    req_valid = '0;
    reset     = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      n_checks++;
      if (resp_valid !== '0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL midflight_drop k=%0d: got valid=%b busy=%b expected 0000/0", k, resp_valid, busy);
      end
      cycle();
    end
    req_valid = 4'b0011;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL midflight_ptr: got %b expected 0001", req_ready);
    end
    cycle();
    req_valid = 4'b0100;
    req_a[2]  = 8'd9;
    req_b[2]  = 8'hF0;
    reset     = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_errors++;
      $display("FAIL reset_ready: got %b expected 0100", req_ready);
    end
    cycle();
    reset = 1'b0;
    cycle();
    req_valid = '0;
    repeat (LAT + 1) cycle();
  endtask

  task automatic test_soak();
    apply_reset();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
          req_valid[i] = 1'b1;
          req_a[i]     = 8'($urandom);
          req_b[i]     = 8'($urandom);
        end
      end
      cycle();
    end
    req_valid = '0;
    repeat (LAT + 1) cycle();
    n_checks++;
    if (max_wait > NREQ - 1) begin
      n_errors++;
      $display("FAIL starvation: got max wait %0d expected <= %0d", max_wait, NREQ - 1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_corners();
    test_fairness();
    test_rotation();
    test_reset_midflight();
    test_soak();
    n_checks++;
    if (sb.size() != 0 || n_acc != n_resp) begin
      n_errors++;
      $display("FAIL drain: got pending=%0d responses=%0d expected pending=0 responses=%0d", sb.size(), n_resp, n_acc);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
